uart_mmio: RTL and testbench



---
 rtl/uart_mmio_pkg.sv | 18 +
 rtl/uart_mmio_if.sv | 11 +
 rtl/uart_mmio_sync_fifo.sv | 44 ++++
 rtl/uart_mmio.sv | 104 ++++++++++
 tb/tb_uart_mmio.sv | 125 ++++++++++++
 5 files changed

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register selects, STATUS field positions and TX FSM states
package uart_mmio_pkg;
  localparam int REG_TX = 1;
  localparam int REG_RX = 2;
  localparam int REG_ST = 3;
  localparam int ST_TX_BUSY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_RX_OVR = 2;
  localparam int ST_TX_FULL = 3;
  localparam int ST_TX_OFL = 4;
  localparam int ST_RX_CNT = 8;
  localparam int ST_TX_CNT = 16;
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_SEND  = 2'd2
  } tx_state_e;
endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: CPU data-bus side of the UART peripheral (IO page access)
interface uart_mmio_if;
  logic        io_sel;
  logic [3:0]  wordaddr;
  logic        rstrb;
  logic        wstrb;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  modport master (output io_sel, wordaddr, rstrb, wstrb, wdata, input rdata);
  modport slave (input io_sel, wordaddr, rstrb, wstrb, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_sync_fifo.sv
// sync_fifo: registered-storage FIFO; push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata_o = mem_q[rd_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with RX/TX FIFOs, sticky error flags and a TX launch FSM
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  uart_mmio_if.slave  bus,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_active,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic        irq
);
  localparam int RW = $clog2(RX_DEPTH) + 1;
  localparam int TW = $clog2(TX_DEPTH) + 1;
  logic rd, wr, sel_tx, sel_rx, sel_st, clr;
  logic rx_full, rx_empty, rx_push, rx_pop;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic [RW-1:0] rx_cnt;
  logic [TW-1:0] tx_cnt;
  logic [7:0] rx_head, tx_head;
  logic ovr_q, ovr_d, ofl_q, ofl_d, tx_busy;
  logic [31:0] status, rdata_q, rdata_d;
  tx_state_e state_q, state_d;
  logic [1:0] tmo_q, tmo_d;
  logic tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk, .resetn, .push_i(rx_push), .pop_i(rx_pop), .wdata_i(rx_byte),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk, .resetn, .push_i(tx_push), .pop_i(tx_pop), .wdata_i(bus.wdata),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );
  // lowest set wordaddr bit wins, so each select masks every bit below it
  always_comb begin
    rd = bus.io_sel & bus.rstrb;
    wr = bus.io_sel & bus.wstrb;
    sel_tx = bus.wordaddr[REG_TX] & ~|bus.wordaddr[REG_TX-1:0];
    sel_rx = bus.wordaddr[REG_RX] & ~|bus.wordaddr[REG_RX-1:0];
    sel_st = bus.wordaddr[REG_ST] & ~|bus.wordaddr[REG_ST-1:0];
    clr = wr & sel_st;
    rx_pop = rd & sel_rx & ~rx_empty;
    rx_push = rx_dv & (~rx_full | rx_pop);
    tx_push = wr & sel_tx & (~tx_full | tx_pop);
    ovr_d = (rx_dv & rx_full & ~rx_pop) | (ovr_q & ~(clr & bus.wdata[ST_RX_OVR]));
    ofl_d = (wr & sel_tx & tx_full & ~tx_pop) | (ofl_q & ~(clr & bus.wdata[ST_TX_OFL]));
    tx_busy = ~tx_empty | (state_q != TX_IDLE) | tx_active;
    status = '0;
    status[ST_TX_BUSY] = tx_busy;
    status[ST_RX_VALID] = ~rx_empty;
    status[ST_RX_OVR] = ovr_q;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_OFL] = ofl_q;
    status[ST_RX_CNT +: 8] = 8'(rx_cnt);
    status[ST_TX_CNT +: 8] = 8'(tx_cnt);
    rdata_d = !rd ? rdata_q :
              sel_rx ? (rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head}) :
              sel_st ? status : 32'd0;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!tx_empty && !tx_active) state_d = TX_START;
      TX_START: if (tx_active) state_d = TX_SEND; else if (tmo_q == 2'd3) state_d = TX_IDLE;
      TX_SEND:  if (!tx_active) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end
  always_comb begin
    tx_pop = (state_q == TX_IDLE) & ~tx_empty & ~tx_active;
    tx_dv_d = tx_pop;
    tx_byte_d = tx_pop ? tx_head : tx_byte_q;
    tmo_d = (state_q == TX_START) ? tmo_q + 2'd1 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= TX_IDLE;
      tmo_q <= '0;
      tx_dv_q <= 1'b0;
      tx_byte_q <= '0;
      ovr_q <= 1'b0;
      ofl_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      tx_dv_q <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      ovr_q <= ovr_d;
      ofl_q <= ofl_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.rdata = rdata_q;
  assign tx_dv = tx_dv_q;
  assign tx_byte = tx_byte_q;
  assign irq = ~rx_empty;
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for register reads and TX launches of uart_mmio
module tb_uart_mmio;
  localparam logic [3:0] A_TX = 4'b0010, A_RX = 4'b0100, A_ST = 4'b1000;
  typedef struct { logic [31:0] exp; logic [31:0] m; string tag; } rd_t;
  logic clk = 0, resetn = 0;
  logic rx_dv = 0, tx_active = 0, tx_dv, irq;
  logic [7:0] rx_byte = 0, tx_byte;
  uart_mmio_if bus();
  rd_t rq[$];
  logic [7:0] txq[$];
  int n_cmp = 0, n_err = 0, tx_n = 0;
  logic act_prev = 0;
  uart_mmio dut (
    .clk(clk), .resetn(resetn), .bus(bus), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_active(tx_active), .tx_dv(tx_dv), .tx_byte(tx_byte), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rdx(input string tag, input logic [3:0] a, input logic [31:0] exp,
                     input logic [31:0] m, input logic dv, input logic [7:0] b);
    rd_t e;
    bus.io_sel = 1; bus.wordaddr = a; bus.rstrb = 1; rx_dv = dv; rx_byte = b;
    rq.push_back('{exp, m, tag});
    tick();
    bus.io_sel = 0; bus.rstrb = 0; rx_dv = 0;
    e = rq.pop_front();
    chk(e.tag, bus.rdata & e.m, e.exp);
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rdx(tag, a, exp, 32'hFFFF_FFFF, 1'b0, 8'h00);
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.io_sel = 1; bus.wordaddr = a; bus.wstrb = 1; bus.wdata = d;
    tick();
    bus.io_sel = 0; bus.wstrb = 0;
  endtask
  task automatic rxb(input logic [7:0] b);
    rx_dv = 1; rx_byte = b;
    tick();
    rx_dv = 0;
  endtask
  // uart_tx model: goes busy 3 cycles after a launch and stays busy 10 cycles
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      repeat (3) @(posedge clk);
      #1 tx_active = 1;
      repeat (10) @(posedge clk);
      #1 tx_active = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      tx_n++;
      chk("tx_gap", {31'd0, act_prev | tx_active}, 32'd0);
      if (txq.size() == 0) chk("tx_queued", 32'(txq.size()), 32'd1);
      else chk("tx_byte", {24'd0, tx_byte}, {24'd0, txq.pop_front()});
    end
    act_prev = tx_active;
  end
  initial begin
    int w;
    bus.io_sel = 0; bus.wordaddr = 0; bus.rstrb = 0; bus.wstrb = 0; bus.wdata = 0;
    repeat (3) tick();
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_txdv", {31'd0, tx_dv}, 0);
    resetn = 1;
    tick();
    rd("rst_status", A_ST, 0);
    rxb(8'h41); rxb(8'h42); rxb(8'h43);
    chk("irq_set", {31'd0, irq}, 1);
    rd("rx0", A_RX, 32'h141);
    rd("rx1", A_RX, 32'h142);
    rd("rx2", A_RX, 32'h143);
    chk("irq_clr", {31'd0, irq}, 0);
    tick(); tick();
    chk("rd_hold", bus.rdata, 32'h143);
    rd("rx_empty", A_RX, 0);
    for (int i = 0; i < 17; i++) rxb(8'(8'h10 + i));
    rd("ovr_status", A_ST, 32'h0000_1006);
    for (int i = 0; i < 16; i++) rd("ovr_data", A_RX, 32'h100 | (32'h10 + i));
    wr(A_ST, 8'h04);
    rd("ovr_clr", A_ST, 0);
    for (int i = 0; i < 16; i++) rxb(8'(8'h60 + i));
    rdx("full_pop", A_RX, 32'h160, 32'hFFFF_FFFF, 1'b1, 8'h99);
    rd("full_status", A_ST, 32'h0000_1002);
    for (int i = 1; i < 16; i++) rd("full_data", A_RX, 32'h100 | (32'h60 + i));
    rd("full_last", A_RX, 32'h199);
    rd("full_empty", A_RX, 0);
    txq.push_back(8'h55); wr(A_TX, 8'h55);
    txq.push_back(8'hAA); wr(A_TX, 8'hAA);
    rdx("tx_busy", A_ST, 1, 1, 1'b0, 8'h00);
    repeat (100) tick();
    chk("tx_count", tx_n, 2);
    chk("tx_drained", 32'(txq.size()), 0);
    rd("tx_idle", A_ST, 0);
    txq.push_back(8'h11); wr(A_TX, 8'h11);
    wr(A_TX, 8'h22);
    wr(A_TX, 8'h33);
    w = 0;
    while (!tx_active && w < 30) begin tick(); w++; end
    chk("mid_active", {31'd0, tx_active}, 1);
    resetn = 0;
    tick(); tick();
    resetn = 1;
    rdx("mid_flush", A_ST, 0, 32'hFFFF_FFFE, 1'b0, 8'h00);
    repeat (100) tick();
    chk("mid_count", tx_n, 3);
    rd("mid_idle", A_ST, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
